adder_stim_check: RTL and testbench

//  Self-checking traffic source and sink for the registered adder benchmark (adder_top).

---
 rtl/adder_stim_check_if.sv | 49 ++++
 rtl/adder_stim_check.sv | 222 ++++++++++++++++++++++
 tb/tb_adder_stim_check.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_stim_check_if.sv
// -----------------------------------------------------------------------------
// adder_stim_check_if
// Bus bundle between the adder stimulus/checker and its environment.
//   start      - single-cycle run request into the checker
//   a, b       - operands driven by the checker to the adder
//   sum        - registered adder result returned to the checker (WIDTH+1 bits)
//   busy/done  - run status from the checker
//   pass       - run verdict, valid while done is high
//   err_count  - saturating mismatch count
//   vec_count  - vectors issued in the current run
// Modports: master = checker side, slave = adder/environment side.
// -----------------------------------------------------------------------------
interface adder_stim_check_if #(
    parameter int unsigned WIDTH = 97
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      err_count;
    logic [15:0]      vec_count;

    modport master (
        input  start,
        input  sum,
        output a,
        output b,
        output busy,
        output done,
        output pass,
        output err_count,
        output vec_count
    );

    modport slave (
        output start,
        output sum,
        input  a,
        input  b,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  vec_count
    );
endinterface

// File: rtl/adder_stim_check.sv
// -----------------------------------------------------------------------------
// adder_stim_check
// Self-checking traffic source and sink for a registered adder. Two LFSRs drive
// operands a/b once per cycle during a run; the predicted a+b travels down a
// LATENCY-deep expected pipeline and is compared with the returned sum.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high
//   bus    - adder_stim_check_if.master (start, a, b, sum, busy, done, pass,
//            err_count, vec_count)
// Optional feature: define ADDER_CHK_CORNER_EN to prepend four fixed corner
// vectors (carry ripple, all-ones, zero, MSB) to every run.
// -----------------------------------------------------------------------------
module adder_stim_check #(
    parameter int unsigned      WIDTH       = 97,
    parameter int unsigned      LATENCY     = 2,
    parameter int unsigned      NUM_VECTORS = 1024,
    parameter logic [WIDTH-1:0] SEED_A      = WIDTH'(1),
    parameter logic [WIDTH-1:0] SEED_B      = WIDTH'(2),
    parameter logic [WIDTH-1:0] TAP_MASK    = WIDTH'(6)
) (
    input logic                clk,
    input logic                reset,
    adder_stim_check_if.master bus
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_A_FIX = (SEED_A == '0) ? WIDTH'(1) : SEED_A;
    localparam logic [WIDTH-1:0] SEED_B_FIX = (SEED_B == '0) ? WIDTH'(1) : SEED_B;
    localparam logic [15:0]      LAST_VEC   = 16'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [15:0]      r_vec_count;
    logic [15:0]      r_err_count;
    logic             r_done;
    logic             r_pass;

    logic [LATENCY-1:0] r_pipe_vld;
    logic [WIDTH:0]     r_pipe_exp [LATENCY];

    logic             w_launch;
    logic             w_last_vec;
    logic             w_pipe_pending;
    logic             w_mismatch;
    logic [15:0]      w_err_next;
    logic [WIDTH:0]   w_sum_exp;
    logic             w_busy;
    logic [WIDTH-1:0] w_a_init;
    logic [WIDTH-1:0] w_b_init;
    logic [WIDTH-1:0] w_a_adv;
    logic [WIDTH-1:0] w_b_adv;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], ^(x & TAP_MASK)};
    endfunction

    assign w_launch   = ((r_state == StIdle) || (r_state == StDone)) && bus.start;
    assign w_last_vec = (r_vec_count == LAST_VEC);
    assign w_sum_exp  = {1'b0, r_a} + {1'b0, r_b};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (bus.start) w_state_next = StRun;
            StRun:   if (w_last_vec) w_state_next = StDrain;
            // Leave once only the final stage (checked this cycle) may still be valid.
            StDrain: if (!w_pipe_pending) w_state_next = StDone;
            StDone:  if (bus.start) w_state_next = StRun;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_busy = (r_state == StRun) || (r_state == StDrain);
    end

    // ---------------------------------------------------------------- operand sources
`ifdef ADDER_CHK_CORNER_EN
    localparam logic [WIDTH-1:0] MSB_ONLY = WIDTH'(1) << (WIDTH - 1);

    logic [WIDTH-1:0] r_lfsr_a;
    logic [WIDTH-1:0] r_lfsr_b;

    // Corner vectors v0..v3 are loaded into a/b directly; the LFSRs sit at the
    // seeds until v4 is issued, then step in lockstep with a/b.
    always_comb begin
        w_a_init = '1;
        w_b_init = WIDTH'(1);
        w_a_adv  = r_lfsr_a;
        w_b_adv  = r_lfsr_b;
        case (r_vec_count)
            16'd0: begin
                w_a_adv = '1;
                w_b_adv = '1;
            end
            16'd1: begin
                w_a_adv = '0;
                w_b_adv = '0;
            end
            16'd2: begin
                w_a_adv = MSB_ONLY;
                w_b_adv = MSB_ONLY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr_a <= '0;
            r_lfsr_b <= '0;
        end else if (w_launch) begin
            r_lfsr_a <= SEED_A_FIX;
            r_lfsr_b <= SEED_B_FIX;
        end else if ((r_state == StRun) && !w_last_vec && (r_vec_count >= 16'd3)) begin
            r_lfsr_a <= lfsr_step(r_lfsr_a);
            r_lfsr_b <= lfsr_step(r_lfsr_b);
        end
    end
`else
    // a/b are the LFSR registers themselves.
    always_comb begin
        w_a_init = SEED_A_FIX;
        w_b_init = SEED_B_FIX;
        w_a_adv  = lfsr_step(r_a);
        w_b_adv  = lfsr_step(r_b);
    end
`endif

    // ---------------------------------------------------------------- expected pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= (r_state == StRun);
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
        end
    end

    // Data is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        r_pipe_exp[0] <= w_sum_exp;
        for (int i = 1; i < int'(LATENCY); i++) begin
            r_pipe_exp[i] <= r_pipe_exp[i-1];
        end
    end

    always_comb begin
        w_pipe_pending = 1'b0;
        for (int i = 0; i < int'(LATENCY) - 1; i++) begin
            w_pipe_pending = w_pipe_pending | r_pipe_vld[i];
        end
    end

    // ---------------------------------------------------------------- check
    assign w_mismatch = r_pipe_vld[LATENCY-1] && (bus.sum != r_pipe_exp[LATENCY-1]);

    always_comb begin
        w_err_next = r_err_count;
        if (w_mismatch && (r_err_count != 16'hFFFF)) begin
            w_err_next = r_err_count + 16'd1;
        end
    end

    // ---------------------------------------------------------------- datapath / status
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_vec_count <= '0;
            r_err_count <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_done <= (w_state_next == StDone);
            // Folds in the final check that lands on the DONE entry edge.
            r_pass <= (w_state_next == StDone) && (w_err_next == '0);
            if (w_launch) begin
                r_a         <= w_a_init;
                r_b         <= w_b_init;
                r_vec_count <= '0;
                r_err_count <= '0;
            end else begin
                r_err_count <= w_err_next;
                if (r_state == StRun) begin
                    r_vec_count <= r_vec_count + 16'd1;
                    // a/b hold on the last vector so DRAIN keeps them stable.
                    if (!w_last_vec) begin
                        r_a <= w_a_adv;
                        r_b <= w_b_adv;
                    end
                end
            end
        end
    end

    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err_count;
    assign bus.vec_count = r_vec_count;

endmodule

// File: tb/tb_adder_stim_check.sv
// -----------------------------------------------------------------------------
// tb_adder_stim_check
// Bench for adder_stim_check: a registered two-stage adder with selectable
// faults feeds sum back; an operand/error model built from the LFSR rules
// predicts every a/b vector and the final error count of each run.
// -----------------------------------------------------------------------------
module tb_adder_stim_check;

    localparam int unsigned W   = 97;
    localparam int          LAT = 2;
    localparam int          NV  = 16;
    localparam logic [W-1:0] SEED_A = W'(1);
    localparam logic [W-1:0] SEED_B = W'(2);
    localparam logic [W-1:0] TAP    = W'(6);
    localparam logic [W:0]   TOPBIT = {1'b1, {W{1'b0}}};

    localparam int FNONE  = 0;
    localparam int FZERO  = 1;
    localparam int FSTUCK = 2;
    localparam int FRAND  = 3;

`ifdef ADDER_CHK_CORNER_EN
    localparam int ZERO_ERRS  = 15;  // v2 expects 0
    localparam int STUCK_ERRS = 3;   // v0, v1, v3 carry into the top bit
`else
    localparam int ZERO_ERRS  = 16;
    localparam int STUCK_ERRS = 0;   // small LFSR values never reach the top bit
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic launch = 1'b0;
    int   cyc = 100000;
    int   cur_fault = FNONE;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [W:0]   rmask [NV];
    logic [W-1:0] exp_a [NV];
    logic [W-1:0] exp_b [NV];
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W:0]   add_sum;
    logic [W:0]   sel_mask;

    adder_stim_check_if #(.WIDTH(W)) bus ();

    adder_stim_check #(
        .WIDTH      (W),
        .LATENCY    (LAT),
        .NUM_VECTORS(NV),
        .SEED_A     (SEED_A),
        .SEED_B     (SEED_B),
        .TAP_MASK   (TAP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] faulted(input logic [W:0] s, input int f,
                                          input logic [W:0] m);
        case (f)
            FZERO:   return '0;
            FSTUCK:  return s & ~TOPBIT;
            FRAND:   return s ^ m;
            default: return s;
        endcase
    endfunction

    // Reference adder: two register stages, then an optional fault on the output.
    always @(posedge clk) begin
        add_a   <= bus.a;
        add_b   <= bus.b;
        add_sum <= {1'b0, add_a} + {1'b0, add_b};
        cyc     <= launch ? 0 : cyc + 1;
    end

    // Cycle k after the start edge carries a[k]; its sum returns in cycle k+LAT.
    always_comb begin
        sel_mask = '0;
        if (cyc >= LAT && cyc < LAT + NV) sel_mask = rmask[cyc-LAT];
        bus.sum = faulted(add_sum, cur_fault, sel_mask);
    end

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] x);
        return {x[W-2:0], ^(x & TAP)};
    endfunction

    task automatic build_model();
        logic [W-1:0] la;
        logic [W-1:0] lb;
        logic [W-1:0] ca [4];
        logic [W-1:0] cb [4];
        la = (SEED_A == '0) ? W'(1) : SEED_A;
        lb = (SEED_B == '0) ? W'(1) : SEED_B;
        ca[0] = '1;              cb[0] = W'(1);
        ca[1] = '1;              cb[1] = '1;
        ca[2] = '0;              cb[2] = '0;
        ca[3] = W'(1) << (W-1);  cb[3] = W'(1) << (W-1);
        for (int k = 0; k < NV; k++) begin
`ifdef ADDER_CHK_CORNER_EN
            if (k < 4) begin
                exp_a[k] = ca[k];
                exp_b[k] = cb[k];
                continue;
            end
`endif
            exp_a[k] = la;
            exp_b[k] = lb;
            la = lfsr_next(la);
            lb = lfsr_next(lb);
        end
    endtask

    function automatic int model_err(input int f);
        int e = 0;
        logic [W:0] s;
        for (int k = 0; k < NV; k++) begin
            s = {1'b0, exp_a[k]} + {1'b0, exp_b[k]};
            if (faulted(s, f, rmask[k]) != s) e++;
        end
        return (e > 65535) ? 65535 : e;
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // One run from IDLE/DONE; optional extra start pulse at cycle mid_start.
    task automatic do_run(input string name, input int fault, input int mid_start,
                          input int exp_err);
        int busy_cyc = 0;
        int c = 0;
        int want_err;
        cur_fault = fault;
        for (int k = 0; k < NV; k++) begin
            rmask[k] = ($urandom_range(2, 0) == 0) ? (TOPBIT >> $urandom_range(W, 0)) : '0;
        end
        want_err = (exp_err < 0) ? model_err(fault) : exp_err;
        bus.start = 1'b1;
        launch    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        launch    = 1'b0;
        while (!bus.done && c < 200) begin
            if (bus.busy) busy_cyc++;
            if (c < NV) check({name, "_ab"}, {bus.a, bus.b}, {exp_a[c], exp_b[c]});
            bus.start = (c == mid_start);
            @(negedge clk);
            c++;
        end
        bus.start = 1'b0;
        check({name, "_done"}, bus.done, 1);
        check({name, "_busy_cycles"}, busy_cyc, NV + LAT);
        check({name, "_vec_count"}, bus.vec_count, NV);
        check({name, "_err_count"}, bus.err_count, want_err);
        check({name, "_pass"}, bus.pass, (want_err == 0));
    endtask

    typedef struct {
        string name;
        int    fault;
        int    mid_start;
        int    exp_err;   // -1: take from the model
    } run_t;

    run_t runs [8];

    initial begin
        runs[0] = '{"clean",          FNONE,  -1, 0};
        runs[1] = '{"restart",        FNONE,  -1, 0};
        runs[2] = '{"start_in_run",   FNONE,   3, 0};
        runs[3] = '{"zero_sum",       FZERO,  -1, ZERO_ERRS};
        runs[4] = '{"stuck_top",      FSTUCK, -1, STUCK_ERRS};
        runs[5] = '{"rand_corrupt_0", FRAND,  -1, -1};
        runs[6] = '{"rand_corrupt_1", FRAND,  -1, -1};
        runs[7] = '{"clean_after",    FNONE,  -1, 0};

        bus.start = 1'b0;
        build_model();
        repeat (3) @(negedge clk);
        check("rst_a", bus.a, 0);
        check("rst_b", bus.b, 0);
        check("rst_status", {bus.busy, bus.done, bus.pass}, 0);
        check("rst_counts", {bus.err_count, bus.vec_count}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", bus.busy, 0);

        for (int r = 0; r < 8; r++) begin
            do_run(runs[r].name, runs[r].fault, runs[r].mid_start, runs[r].exp_err);
            repeat (2) @(negedge clk);
            check({runs[r].name, "_done_hold"}, bus.done, 1);
        end

        // Reset five cycles into a run discards everything.
        cur_fault = FNONE;
        bus.start = 1'b1;
        launch    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        launch    = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        check("mid_vec_count", bus.vec_count, 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_ab", {bus.a, bus.b}, 0);
        check("mid_rst_status", {bus.busy, bus.done, bus.pass}, 0);
        check("mid_rst_counts", {bus.err_count, bus.vec_count}, 0);
        repeat (3) @(negedge clk);
        check("mid_rst_idle", {bus.busy, bus.done, bus.err_count}, 0);
        do_run("post_reset", FNONE, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
